mem_arbiter: RTL and testbench
==============================

# mem_arbiter

- Shares one single-ported unified memory between the instruction-fetch port (F stage) and the data port (M stage) of the pipelined MIPS core.
- One access is in flight at a time; the arbiter latches the granted request and drives the memory handshake.
- While a port's access is pending, it raises that port's stall (`stallF` / `stallM`) to the hazard unit.
- The data port has priority, with an optional anti-starvation guard for fetch.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `STARVE_MAX`, 4, consecutive data grants tolerated while fetch waits (used only with `MEM_ARB_FAIR_EN`)

- `clk` in 1: clock; everything is updated on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `i_req` in 1: fetch read request, held until `i_done`.
- `i_addr` in AW: fetch address.
- `i_rdata` out DW: fetch read data, valid only while `i_done` = 1.
- `i_done` out 1: fetch access completes this cycle.
- `d_req` in 1: data request, held until `d_done`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in AW, `d_wdata` in DW: data address and write data.
- `d_rdata` out DW: data read data, valid only while `d_done` = 1 and the access was a read.
- `d_done` out 1: data access completes this cycle.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out AW, `mem_wdata` out DW: memory request; all are registered and stable for the whole access.
- `mem_rdata` in DW, `mem_ready` in 1: memory response; `mem_ready` = 1 ends the access in that cycle.
- `stallF` out 1 = `i_req` & ~`i_done`.
- `stallM` out 1 = `d_req` & ~`d_done`.
- `busy` out 1: state ≠ IDLE.

## Operation
- **States:**
  - IDLE: no access in flight.
  - BUSY_I: fetch access in flight.
  - BUSY_D: data access in flight.
- **IDLE:**
  - Sample `d_req` and `i_req`.
  - Both low: stay in IDLE.
  - Only one high: grant it.
  - Both high: grant data (subject to the fairness rule under Configuration).
  - On a grant edge, latch the address, write data and write-enable into the `mem_*` registers.
  - Fetch grants force `mem_we` = 0 and `mem_wdata` = 0.
  - Set `mem_req` = 1 and move to BUSY_I or BUSY_D.
- **BUSY_x with `mem_ready` = 0:** hold all `mem_*` outputs unchanged; no timeout.
- **BUSY_x with `mem_ready` = 1:**
  - `x_done` = 1 combinationally in the same cycle.
  - `x_rdata` passes `mem_rdata` through.
  - Next edge: `mem_req` ← 0, state ← IDLE.
- **Always-zero outputs:**
  - `i_done` and `d_done` are 0 outside their own BUSY state.
  - `i_rdata` and `d_rdata` are 0 whenever their done is 0.
- **Ignored inputs:**
  - `mem_ready` is ignored in IDLE.
  - Request inputs are ignored while BUSY; no preemption.
- **Requester rule:** a requester whose `req` is still high in IDLE after its done was serviced as a new access. The pipeline advances on done, so the request it then presents is the next access.
- **Data reads:** `d_rdata` on a write completion is don't-care and is driven from `mem_rdata`.

## Timing
- Reset (async assert, sync release):
  - State = IDLE.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` = 0.
  - Fairness counter = 0.
  - Derived outputs are therefore 0, except `stallF`/`stallM`, which follow their `req` inputs.
- Reset mid-access: the access is abandoned and `mem_req` drops immediately. The memory must tolerate a dropped request.
- Latency, request high in IDLE cycle T:
  - `mem_req` = 1 from T+1.
  - With a 0-wait memory (`mem_ready` = 1 in T+1), done is at T+1.
  - With W wait cycles, done is at T+1+W.
  - The next grant is possible at T+2+W (one IDLE bubble per access).
- Simultaneous `i_req` and `d_req` in IDLE: data wins. Fetch waits a minimum of 2 extra cycles, with `stallF` held high throughout.

## Configuration
- **`MEM_ARB_FAIR_EN` defined:**
  - A counter of width $clog2(STARVE_MAX+1) increments on each data grant made while `i_req` = 1.
  - When the counter equals `STARVE_MAX`, the next IDLE cycle with both requests high grants fetch.
  - The counter clears on any fetch grant, or in any IDLE cycle with `i_req` = 0.
- **`MEM_ARB_FAIR_EN` undefined:** strict data priority; no counter is built and `STARVE_MAX` is unused.

## Test plan
- Reset low mid-BUSY_D (`mem_addr` = 0x40) → same cycle `mem_req` = 0, `mem_addr` = 0, `busy` = 0, `d_done` = 0; after release the arbiter is idle.
- `i_req`=1, `i_addr`=0x100, 0-wait memory returning 0x8C220004 → `mem_req` = 1 with `mem_addr` = 0x100 and `mem_we` = 0 next cycle; same cycle `i_done` = 1 and `i_rdata` = 0x8C220004; `stallF` low on the done cycle.
- `d_req`=1, `d_we`=1, `d_addr`=0x54, `d_wdata`=7 with 3 wait cycles → `mem_*` stable for 4 cycles; `d_done` only on the 4th; `stallM` high for the 4 prior cycles (IDLE + 3 waits).
- `i_req` and `d_req` asserted together in IDLE → BUSY_D first; fetch granted on the following IDLE cycle.
- With `MEM_ARB_FAIR_EN`, `STARVE_MAX`=4: `i_req` held high, `d_req` re-presented back-to-back → exactly 4 data accesses, then 1 fetch, then data again.
- Without the macro, same stimulus → fetch is never granted while `d_req` stays high.
- `mem_ready` pulsed high in IDLE → no done output; state unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the fetch port (F)
// and the data port (M) of the pipelined core. One access is in flight at a
// time. The data port wins ties. Defining MEM_ARB_FAIR_EN adds a starvation
// guard that hands the memory to fetch after STARVE_MAX consecutive data
// grants made while fetch was waiting.
module mem_arbiter #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          reset,

   // fetch port
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] i_rdata,
   output logic          i_done,

   // data port
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_done,

   // memory side
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,

   // hazard unit / status
   output logic          stallF,
   output logic          stallM,
   output logic          busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2
   } state_t;

   state_t          r_state;
   logic            r_mem_req;
   logic            r_mem_we;
   logic [AW-1:0]   r_mem_addr;
   logic [DW-1:0]   r_mem_wdata;

   logic            w_idle;
   logic            w_fetch_first;
   logic            w_grant_i;
   logic            w_grant_d;
   logic            w_i_done;
   logic            w_d_done;

   // A zero limit would hand every tie to fetch and collapse the counter width.
   if (STARVE_MAX < 1) begin : g_bad_starve_max
      $error("mem_arbiter: STARVE_MAX must be at least 1");
   end

   assign w_idle = (r_state == ST_IDLE);

`ifdef MEM_ARB_FAIR_EN
   localparam int unsigned CW = $clog2(STARVE_MAX + 1);

   logic [CW-1:0] r_starve;

   // Fetch overrides data priority once the data port has had its quota.
   always_comb begin
      w_fetch_first = (r_starve == CW'(STARVE_MAX));
   end

   // Count data grants taken while fetch waits; any fetch grant or an idle
   // cycle without a fetch request starts the count again.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_starve <= '0;
      end else if (w_idle) begin
         if (!i_req || w_grant_i) begin
            r_starve <= '0;
         end else if (w_grant_d) begin
            r_starve <= r_starve + CW'(1);
         end
      end
   end
`else
   // Strict data priority.
   always_comb begin
      w_fetch_first = 1'b0;
   end
`endif

   // Grant decision, only meaningful in IDLE; requests are ignored while busy.
   always_comb begin
      w_grant_i = w_idle & i_req & (~d_req | w_fetch_first);
      w_grant_d = w_idle & d_req & ~w_grant_i;
   end

   // Access FSM: latch the winning request into the memory registers and
   // hold them until the memory signals ready.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_grant_d) begin
                  r_state     <= ST_BUSY_D;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= d_we;
                  r_mem_addr  <= d_addr;
                  r_mem_wdata <= d_wdata;
               end else if (w_grant_i) begin
                  r_state     <= ST_BUSY_I;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= i_addr;
                  r_mem_wdata <= '0;
               end
            end
            ST_BUSY_I, ST_BUSY_D: begin
               if (mem_ready) begin
                  r_state   <= ST_IDLE;
                  r_mem_req <= 1'b0;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   // Completion is combinational on mem_ready in the owning BUSY state.
   always_comb begin
      w_i_done = (r_state == ST_BUSY_I) & mem_ready;
      w_d_done = (r_state == ST_BUSY_D) & mem_ready;
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

   assign i_done    = w_i_done;
   assign d_done    = w_d_done;
   assign i_rdata   = w_i_done ? mem_rdata : '0;
   assign d_rdata   = w_d_done ? mem_rdata : '0;

   assign stallF    = i_req & ~w_i_done;
   assign stallM    = d_req & ~w_d_done;
   assign busy      = ~w_idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a queue scoreboard per port.
module tb_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          i_done;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_done;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
   logic          stallF;
   logic          stallM;
   logic          busy;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stallF(stallF), .stallM(stallM), .busy(busy)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   exp_t        qI[$];
   exp_t        qD[$];
   int          total = 0;
   int          bad = 0;
   int          dcount = 0;
   int          icount = 0;
   int unsigned wait_cfg = 0;
   bit          force_rdy = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rd_of(input logic [31:0] a);
      if (a == 32'h100) return 32'h8C220004;
      return {a[15:0], 16'hA5A5};
   endfunction

   // Memory model: ready after wait_cfg wait cycles of a held request.
   initial begin
      int unsigned wcnt;
      wcnt      = 0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_req && reset) begin
            mem_ready = (wcnt == wait_cfg);
            mem_rdata = rd_of(mem_addr);
            wcnt++;
         end else begin
            wcnt      = 0;
            mem_ready = force_rdy;
            mem_rdata = force_rdy ? 32'hDEADBEEF : 32'h0;
         end
      end
   end

   // Monitor: pop and compare whenever a port reports completion.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (i_done && d_done) check("both_done", 32'd1, 32'd0);
         if (i_done) begin
            if (qI.size() == 0) begin
               check("i_done_unexpected", 32'd1, 32'd0);
            end else begin
               e = qI.pop_front();
               check("i_rdata", i_rdata, e.rdata);
               check("i_mem_addr", mem_addr, e.addr);
               check("i_mem_we", 32'(mem_we), 32'd0);
               check("i_mem_wdata", mem_wdata, 32'd0);
            end
            icount++;
         end
         if (d_done) begin
            if (qD.size() == 0) begin
               check("d_done_unexpected", 32'd1, 32'd0);
            end else begin
               e = qD.pop_front();
               check("d_mem_addr", mem_addr, e.addr);
               check("d_mem_we", 32'(mem_we), 32'(e.we));
               if (e.we) check("d_mem_wdata", mem_wdata, e.wdata);
               else      check("d_rdata", d_rdata, e.rdata);
            end
            dcount++;
         end
      end
   end

   // n = negedges from request to done (IDLE cycle counts as 1).
   task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input bit keep, input bit chk_mem,
                           output int n, output int stall_hi);
      exp_t e;
      int   unstable;
      bit   done;
      e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
      qD.push_back(e);
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      n = 0; stall_hi = 0; unstable = 0; done = 1'b0;
      while (!done && n < 200) begin
         @(negedge clk);
         #3;
         n++;
         if (d_done) begin
            done = 1'b1;
            check("stallM_on_done", 32'(stallM), 32'd0);
         end else if (stallM) begin
            stall_hi++;
         end
         if (chk_mem && n > 1)
            if (!(mem_req && mem_addr == addr && mem_we == we && mem_wdata == wdata)) unstable++;
      end
      if (!done) check("d_done_timeout", 32'd0, 32'd1);
      if (chk_mem) check("d_mem_stable", 32'(unstable), 32'd0);
      @(posedge clk);
      #1;
      if (!keep) begin
         d_req = 1'b0;
         d_we  = 1'b0;
      end
   endtask

   task automatic i_access(input logic [31:0] addr, input logic [31:0] rdata, input bit chk_mem,
                           output int n, output int stall_hi, output int d_seen);
      exp_t e;
      int   unstable;
      bit   done;
      e.we = 1'b0; e.addr = addr; e.wdata = '0; e.rdata = rdata;
      qI.push_back(e);
      i_req = 1'b1; i_addr = addr;
      n = 0; stall_hi = 0; unstable = 0; done = 1'b0; d_seen = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         #3;
         n++;
         if (i_done) begin
            done   = 1'b1;
            d_seen = dcount;
            check("stallF_on_done", 32'(stallF), 32'd0);
         end else if (stallF) begin
            stall_hi++;
         end
         if (chk_mem && n > 1)
            if (!(mem_req && mem_addr == addr && !mem_we && mem_wdata == 32'h0)) unstable++;
      end
      if (!done) check("i_done_timeout", 32'd0, 32'd1);
      if (chk_mem) check("i_mem_stable", 32'(unstable), 32'd0);
      @(posedge clk);
      #1;
      i_req = 1'b0;
   endtask

   initial begin
      int          n_d, sh_d, n_i, sh_i, ds, dbase;
      logic [31:0] f_addr[6];
      logic [31:0] f_data[6];
      f_addr = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h410, 32'h414};
      f_data = '{32'h0400A5A5, 32'h0404A5A5, 32'h0408A5A5,
                 32'h040CA5A5, 32'h0410A5A5, 32'h0414A5A5};

      reset = 1'b0; i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", {30'd0, i_done, d_done}, 32'd0);
      check("rst_rdata", i_rdata | d_rdata, 32'd0);
      i_req = 1'b1;
      #1;
      check("rst_stallF_follows", 32'(stallF), 32'd1);
      i_req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // 0-wait fetch
      wait_cfg = 0;
      i_access(32'h100, 32'h8C220004, 1'b1, n_i, sh_i, ds);
      check("fetch0_latency", 32'(n_i), 32'd2);
      check("fetch0_stall_cycles", 32'(sh_i), 32'd1);

      // data write with 3 wait cycles
      wait_cfg = 3;
      d_access(1'b1, 32'h54, 32'd7, 32'h0, 1'b0, 1'b1, n_d, sh_d);
      check("dwr3_latency", 32'(n_d), 32'd5);
      check("dwr3_stall_cycles", 32'(sh_d), 32'd4);

      // data read, 0 wait
      wait_cfg = 0;
      d_access(1'b0, 32'h200, 32'h0, 32'h0200A5A5, 1'b0, 1'b1, n_d, sh_d);
      check("drd0_latency", 32'(n_d), 32'd2);

      // simultaneous requests: data first, fetch on the following IDLE
      dbase = dcount;
      fork
         d_access(1'b0, 32'h300, 32'h0, 32'h0300A5A5, 1'b0, 1'b0, n_d, sh_d);
         i_access(32'h104, 32'h0104A5A5, 1'b0, n_i, sh_i, ds);
      join
      check("tie_d_latency", 32'(n_d), 32'd2);
      check("tie_i_latency", 32'(n_i), 32'd4);
      check("tie_stallF_cycles", 32'(sh_i), 32'd3);
      check("tie_d_before_i", 32'(ds - dbase), 32'd1);

      // mem_ready pulse in IDLE is ignored
      @(negedge clk);
      force_rdy = 1'b1;
      #3;
      check("idle_rdy_done", {30'd0, i_done, d_done}, 32'd0);
      check("idle_rdy_busy", 32'(busy), 32'd0);
      @(negedge clk);
      force_rdy = 1'b0;
      #3;
      check("idle_rdy_busy_after", 32'(busy), 32'd0);
      check("idle_rdy_mem_req", 32'(mem_req), 32'd0);
      @(posedge clk);
      #1;

      // reset during a data access
      wait_cfg = 50;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      @(negedge clk);
      @(negedge clk);
      #3;
      check("midrst_pre_busy", 32'(busy), 32'd1);
      check("midrst_pre_addr", mem_addr, 32'h40);
      reset = 1'b0;
      #1;
      check("midrst_mem_req", 32'(mem_req), 32'd0);
      check("midrst_mem_addr", mem_addr, 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_d_done", 32'(d_done), 32'd0);
      d_req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      wait_cfg = 0;
      @(posedge clk);
      #1;
      check("midrst_after_busy", 32'(busy), 32'd0);
      check("midrst_after_mem_req", 32'(mem_req), 32'd0);

      // fetch held high while data is re-presented back to back
      dbase = dcount;
      fork
         begin
            for (int k = 0; k < 6; k++)
               d_access(1'b0, f_addr[k], 32'h0, f_data[k], (k < 5), 1'b0, n_d, sh_d);
         end
         i_access(32'h500, 32'h0500A5A5, 1'b0, n_i, sh_i, ds);
      join
`ifdef MEM_ARB_FAIR_EN
      check("fair_d_before_i", 32'(ds - dbase), 32'd4);
`else
      check("strict_d_before_i", 32'(ds - dbase), 32'd6);
`endif
      check("stream_d_total", 32'(dcount - dbase), 32'd6);

      repeat (2) @(posedge clk);
      #1;
      check("scoreboard_qI_empty", 32'(qI.size()), 32'd0);
      check("scoreboard_qD_empty", 32'(qD.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
